// File: rtl/std_cache_axi_limiter.sv
// std_cache_axi_limiter
//
// Purpose:
//    Sits between the cache subsystem's single AXI master port and the system
//    interconnect. Outstanding reads and writes are counted per source class
//    (I$, D$, bypass), which is decoded from the low four ID bits. New AR/AW
//    requests are throttled per class against configurable limits. A drain
//    handshake lets fence, flush and power-down logic wait until the memory
//    side is quiescent. Every channel is combinational pass-through; only the
//    AR and AW valid/ready pairs are gated.
//
// Ports:
//    clk_i       clock, all state on the rising edge
//    rst_i       synchronous active-high reset
//    slv_req_i   AXI request from the cache subsystem
//    slv_resp_o  AXI response to the cache subsystem
//    mst_req_o   AXI request to the interconnect
//    mst_resp_i  AXI response from the interconnect
//    drain_i     level request: block new AR/AW and wait for quiescence
//    drained_o   nothing outstanding and new requests blocked
//    busy_o      at least one outstanding counter is nonzero
//    err_o       sticky: a response arrived while its class counter was zero

// Default configuration and AXI channel types. A real integration overrides
// axi_req_t/axi_rsp_t with the cache subsystem's own structs; they only need
// the field names used below.
package std_cache_axi_limiter_pkg;

   typedef struct packed {
      int unsigned AxiIdWidth;
      int unsigned AxiAddrWidth;
      int unsigned AxiDataWidth;
   } cfg_t;

   localparam cfg_t cfg_empty = '{AxiIdWidth: 4, AxiAddrWidth: 32, AxiDataWidth: 64};

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
   } ax_chan_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } w_chan_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_chan_t;

   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } axi_rsp_t;

endpackage

module std_cache_axi_limiter #(
   parameter std_cache_axi_limiter_pkg::cfg_t CVA6Cfg = std_cache_axi_limiter_pkg::cfg_empty,
   parameter type axi_req_t = std_cache_axi_limiter_pkg::axi_req_t,
   parameter type axi_rsp_t = std_cache_axi_limiter_pkg::axi_rsp_t,
   parameter int unsigned MaxRdTxns = 4,
   parameter int unsigned MaxWrTxns = 4
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  axi_req_t slv_req_i,
   output axi_rsp_t slv_resp_o,
   output axi_req_t mst_req_o,
   input  axi_rsp_t mst_resp_i,
   input  logic     drain_i,
   output logic     drained_o,
   output logic     busy_o,
   output logic     err_o
);

   localparam int unsigned IdW = CVA6Cfg.AxiIdWidth;
   localparam int unsigned RdW = $clog2(MaxRdTxns + 1);
   localparam int unsigned WrW = $clog2(MaxWrTxns + 1);

   localparam logic [RdW-1:0] RdMax = RdW'(MaxRdTxns);
   localparam logic [WrW-1:0] WrMax = WrW'(MaxWrTxns);

   // Class encoding, also used as the counter index.
   localparam logic [1:0] CLS_I   = 2'd0;
   localparam logic [1:0] CLS_D   = 2'd1;
   localparam logic [1:0] CLS_BYP = 2'd2;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      DRAINED
   } state_e;

   state_e state, state_next;

   logic [RdW-1:0] rd_cnt [3];
   logic [RdW-1:0] rd_cnt_next [3];
   logic [WrW-1:0] wr_cnt [3];
   logic [WrW-1:0] wr_cnt_next [3];

   logic [IdW-1:0] ar_id, aw_id, r_id, b_id;
   logic [1:0]     ar_cls, aw_cls, r_cls, b_cls;
   logic [RdW-1:0] ar_cnt;
   logic [WrW-1:0] aw_cnt;
   logic           ar_ok, aw_ok;
   logic           ar_hs, aw_hs, r_done, b_done;
   logic [2:0]     rd_inc, rd_dec, wr_inc, wr_dec;
   logic           rd_under, wr_under;
   logic           idle_next;
   logic           err;

   // Bit 3 set marks a bypass access, all-zero is the I$, everything else
   // (including unmapped IDs) is charged to the D$.
   function automatic logic [1:0] decode_class(input logic [3:0] id);
      if (id[3]) begin
         return CLS_BYP;
      end else if (id == 4'b0000) begin
         return CLS_I;
      end else begin
         return CLS_D;
      end
   endfunction

   assign ar_id = slv_req_i.ar.id;
   assign aw_id = slv_req_i.aw.id;
   assign r_id  = mst_resp_i.r.id;
   assign b_id  = mst_resp_i.b.id;

   assign ar_cls = decode_class(ar_id[3:0]);
   assign aw_cls = decode_class(aw_id[3:0]);
   assign r_cls  = decode_class(r_id[3:0]);
   assign b_cls  = decode_class(b_id[3:0]);

   // Handshakes are observed on the interconnect side so that only requests
   // that actually left are counted.
   assign ar_hs  = mst_req_o.ar_valid & mst_resp_i.ar_ready;
   assign aw_hs  = mst_req_o.aw_valid & mst_resp_i.aw_ready;
   assign r_done = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
   assign b_done = mst_resp_i.b_valid & slv_req_i.b_ready;

   // The gates only look at registered state/counters and the slave-side ID,
   // so neither valid nor ready feeds back on itself.
   always_comb begin
      ar_cnt = '0;
      aw_cnt = '0;
      for (int c = 0; c < 3; c++) begin
         if (ar_cls == 2'(c)) ar_cnt = rd_cnt[c];
         if (aw_cls == 2'(c)) aw_cnt = wr_cnt[c];
      end
      ar_ok = (state == RUN) && (ar_cnt < RdMax);
      aw_ok = (state == RUN) && (aw_cnt < WrMax);
   end

   // Pass every channel straight through and gate only the AR/AW pairs.
   // W beats are never held back, so writes already accepted always complete.
   always_comb begin
      mst_req_o           = slv_req_i;
      mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_ok;
      mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_ok;
      slv_resp_o          = mst_resp_i;
      slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_ok;
      slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_ok;
   end

   // Next counter values. A simultaneous increment and decrement cancel out;
   // a lone decrement at zero saturates and flags an underflow instead.
   always_comb begin
      rd_under = 1'b0;
      wr_under = 1'b0;
      for (int c = 0; c < 3; c++) begin
         rd_inc[c] = ar_hs  && (ar_cls == 2'(c));
         rd_dec[c] = r_done && (r_cls  == 2'(c));
         wr_inc[c] = aw_hs  && (aw_cls == 2'(c));
         wr_dec[c] = b_done && (b_cls  == 2'(c));

         rd_cnt_next[c] = rd_cnt[c];
         if (rd_inc[c] && !rd_dec[c]) begin
            rd_cnt_next[c] = rd_cnt[c] + RdW'(1);
         end else if (rd_dec[c] && !rd_inc[c]) begin
            if (rd_cnt[c] == '0) begin
               rd_under = 1'b1;
            end else begin
               rd_cnt_next[c] = rd_cnt[c] - RdW'(1);
            end
         end

         wr_cnt_next[c] = wr_cnt[c];
         if (wr_inc[c] && !wr_dec[c]) begin
            wr_cnt_next[c] = wr_cnt[c] + WrW'(1);
         end else if (wr_dec[c] && !wr_inc[c]) begin
            if (wr_cnt[c] == '0) begin
               wr_under = 1'b1;
            end else begin
               wr_cnt_next[c] = wr_cnt[c] - WrW'(1);
            end
         end
      end
   end

   // busy_o reflects the registered counters; idle_next looks one step ahead
   // so DRAINED is reached the cycle after the last completion.
   always_comb begin
      busy_o    = 1'b0;
      idle_next = 1'b1;
      for (int c = 0; c < 3; c++) begin
         if ((rd_cnt[c] != '0) || (wr_cnt[c] != '0)) busy_o = 1'b1;
         if ((rd_cnt_next[c] != '0) || (wr_cnt_next[c] != '0)) idle_next = 1'b0;
      end
   end

   // Drain FSM next-state logic. Dropping drain_i always returns to RUN,
   // even if the drain never completed.
   always_comb begin
      state_next = state;
      unique case (state)
         RUN: begin
            if (drain_i) state_next = DRAIN;
         end
         DRAIN: begin
            if (!drain_i) begin
               state_next = RUN;
            end else if (idle_next) begin
               state_next = DRAINED;
            end
         end
         DRAINED: begin
            if (!drain_i) state_next = RUN;
         end
         default: state_next = RUN;
      endcase
   end

   assign drained_o = (state == DRAINED);
   assign err_o     = err;

   // State, counters and the sticky error flag. Reset drops in-flight
   // bookkeeping, so late responses after a reset show up as underflows.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= RUN;
         err   <= 1'b0;
         for (int c = 0; c < 3; c++) begin
            rd_cnt[c] <= '0;
            wr_cnt[c] <= '0;
         end
      end else begin
         state <= state_next;
         err   <= err | rd_under | wr_under;
         for (int c = 0; c < 3; c++) begin
            rd_cnt[c] <= rd_cnt_next[c];
            wr_cnt[c] <= wr_cnt_next[c];
         end
      end
   end

endmodule
